// File: rtl/UART_pkg.sv
// Shared types for the UART transmit-side arbiter: FSM state encoding and requester limit.
package UART_pkg;

    localparam int TX_ARB_MAX_REQ = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } tx_arb_state_t;

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr_i, wrapping to 0.
module uart_rr_pick #(
    parameter  int N_REQ = 2,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic             vld_o,
    output logic [IDX_W-1:0] idx_o
);

    int pos;

    // Walk from the farthest rotated slot down to rr_ptr_i so the nearest hit wins.
    always_comb begin
        vld_o = 1'b0;
        idx_o = '0;
        pos   = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = int'(rr_ptr_i) + k;
            if (pos >= N_REQ) begin
                pos = pos - N_REQ;
            end
            if (req_i[pos]) begin
                vld_o = 1'b1;
                idx_o = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin owner of the shared UART transmitter: one byte per grant, load -> send -> wait for pending flag.
// Optional transmit watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import UART_pkg::*;
#(
    parameter  int N_REQ          = 2,
    parameter  int TIMEOUT_CYCLES = 65535,
    localparam int IDX_W          = $clog2(N_REQ)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic [N_REQ-1:0]     req_done,
    output logic [7:0]           Tx_Data,
    output logic                 tx_data_en,
    output logic                 tx_send,
    output logic                 tx_send_en,
    input  logic                 tx_send_w,
    output logic                 busy,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 timeout_err,
    output tx_arb_state_t        Arb_state_out
);

    if (N_REQ < 2 || N_REQ > TX_ARB_MAX_REQ || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_err
        $error("uart_tx_arbiter: parameter out of range");
    end

    tx_arb_state_t    state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [7:0]       hold_q, hold_d;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] rr_next;
    logic             tmo_hit;

    uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req_i    (req_valid),
        .rr_ptr_i (rr_ptr_q),
        .vld_o    (pick_vld),
        .idx_o    (pick_idx)
    );

    assign rr_next = (grant_q == IDX_W'(N_REQ - 1)) ? '0 : grant_q + IDX_W'(1);

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [15:0] tmo_cnt_q;

    // Counts cycles spent waiting on the UART; zeroed while the send strobe goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
        end else if (state_q == SEND) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WAIT_BUSY || state_q == WAIT_DONE) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
        end
    end

    assign tmo_hit = (state_q == WAIT_BUSY || state_q == WAIT_DONE) &&
                     (tmo_cnt_q == 16'(TIMEOUT_CYCLES));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        hold_d      = hold_q;
        req_ready   = '0;
        req_done    = '0;
        tx_data_en  = 1'b0;
        tx_send_en  = 1'b0;
        tx_send     = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    req_ready[pick_idx] = 1'b1;
                    hold_d              = req_data[{pick_idx, 3'b000} +: 8];
                    grant_d             = pick_idx;
                    state_d             = LOAD;
                end
            end
            LOAD: begin
                tx_data_en = 1'b1;
                state_d    = SEND;
            end
            SEND: begin
                tx_send_en = 1'b1;
                tx_send    = 1'b1;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_send_w) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (!tx_send_w) begin
                    req_done[grant_q] = 1'b1;
                    rr_ptr_d          = rr_next;
                    state_d           = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Watchdog abort: withdraw the pending send and move on without a completion.
        if (tmo_hit) begin
            timeout_err = 1'b1;
            tx_send_en  = 1'b1;
            tx_send     = 1'b0;
            req_done    = '0;
            rr_ptr_d    = rr_next;
            state_d     = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            hold_q   <= hold_d;
        end
    end

    assign Tx_Data       = hold_q;
    assign busy          = (state_q != IDLE);
    assign grant_id      = grant_q;
    assign Arb_state_out = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a 2-requester instance for the main flows and a 4-requester one for wrap-around.
module tb_uart_tx_arbiter;
    import UART_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [1:0]    rv2, rdy2, dn2;
    logic [15:0]   rd2;
    logic [7:0]    td2;
    logic          tde2, ts2, tse2, w2, busy2, te2;
    logic [0:0]    gid2;
    tx_arb_state_t st2;

    logic [3:0]    rv4, rdy4, dn4;
    logic [31:0]   rd4;
    logic [7:0]    td4;
    logic          tde4, ts4, tse4, w4, busy4, te4;
    logic [1:0]    gid4;
    tx_arb_state_t st4;

    uart_tx_arbiter #(.N_REQ(2), .TIMEOUT_CYCLES(20)) dut2 (
        .clk(clk), .rst(rst), .req_valid(rv2), .req_data(rd2), .req_ready(rdy2), .req_done(dn2),
        .Tx_Data(td2), .tx_data_en(tde2), .tx_send(ts2), .tx_send_en(tse2), .tx_send_w(w2),
        .busy(busy2), .grant_id(gid2), .timeout_err(te2), .Arb_state_out(st2)
    );

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(20)) dut4 (
        .clk(clk), .rst(rst), .req_valid(rv4), .req_data(rd4), .req_ready(rdy4), .req_done(dn4),
        .Tx_Data(td4), .tx_data_en(tde4), .tx_send(ts4), .tx_send_en(tse4), .tx_send_w(w4),
        .busy(busy4), .grant_id(gid4), .timeout_err(te4), .Arb_state_out(st4)
    );

    // UART send-pending models: set one cycle after a send write, cleared hold+1 cycles later.
    int   hold2  = 3;
    logic stuck2 = 1'b0;
    int   cnt2;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            w2 <= 1'b0; cnt2 <= 0;
        end else if (tse2 && !(stuck2 && ts2)) begin
            w2 <= ts2; cnt2 <= hold2;
        end else if (w2) begin
            if (cnt2 == 0) w2 <= 1'b0;
            else cnt2 <= cnt2 - 1;
        end
    end

    int cnt4;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            w4 <= 1'b0; cnt4 <= 0;
        end else if (tse4) begin
            w4 <= ts4; cnt4 <= 3;
        end else if (w4) begin
            if (cnt4 == 0) w4 <= 1'b0;
            else cnt4 <= cnt4 - 1;
        end
    end

    logic te_seen2 = 1'b0;
    always @(posedge clk) if (te2) te_seen2 <= 1'b1;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rv2 = '0; rd2 = '0; rv4 = '0; rd4 = '0;
        #3;
        n_tests++;
        if ({rdy2, dn2, tde2, tse2, ts2, busy2, te2} !== 9'b0) begin
            n_fail++; $display("FAIL reset_strobes got %b want 0", {rdy2, dn2, tde2, tse2, ts2, busy2, te2});
        end
        n_tests++;
        if (td2 !== 8'h00) begin n_fail++; $display("FAIL reset_txdata got %h want 00", td2); end
        n_tests++;
        if (gid2 !== 1'b0) begin n_fail++; $display("FAIL reset_grant got %0d want 0", gid2); end
        n_tests++;
        if (st2 !== IDLE) begin n_fail++; $display("FAIL reset_state got %0d want IDLE", st2); end
        cyc(); cyc();
        rst = 1'b0;
    endtask

    task automatic test_single();
        int n;
        hold2 = 100;
        cyc(); rv2 = 2'b01; rd2 = 16'h0055; #1;
        n_tests++;
        if (rdy2 !== 2'b01) begin n_fail++; $display("FAIL single_ready got %b want 01", rdy2); end
        cyc(); rv2 = 2'b00; rd2 = 16'h0000; #1;
        n_tests++;
        if (!(tde2 === 1'b1 && td2 === 8'h55 && st2 === LOAD))
            begin n_fail++; $display("FAIL single_load got en=%b data=%h want en=1 data=55", tde2, td2); end
        cyc(); #1;
        n_tests++;
        if (!(tse2 === 1'b1 && ts2 === 1'b1))
            begin n_fail++; $display("FAIL single_send got en=%b send=%b want 1 1", tse2, ts2); end
        n = 0;
        while (dn2 == 2'b00 && n < 300) begin cyc(); #1; n++; end
        n_tests++;
        if (dn2 !== 2'b01) begin n_fail++; $display("FAIL single_done got %b want 01", dn2); end
        n_tests++;
        if (n != 102) begin n_fail++; $display("FAIL single_done_time got %0d want 102", n); end
        n_tests++;
        if (gid2 !== 1'b0) begin n_fail++; $display("FAIL single_grant got %0d want 0", gid2); end
        cyc(); #1;
        n_tests++;
        if (!(busy2 === 1'b0 && st2 === IDLE && td2 === 8'h55))
            begin n_fail++; $display("FAIL single_idle got busy=%b st=%0d data=%h want 0 IDLE 55", busy2, st2, td2); end
        hold2 = 3;
    endtask

    task automatic test_contention();
        logic [7:0] got_d [4];
        logic [0:0] got_g [4];
        logic [7:0] exp_d [4];
        int k, n;
        exp_d[0] = 8'hA1; exp_d[1] = 8'hB2; exp_d[2] = 8'hA1; exp_d[3] = 8'hB2;
        rst = 1'b1; #1; rst = 1'b0;
        rv2 = 2'b11; rd2 = 16'hB2A1;
        k = 0; n = 0;
        while (k < 4 && n < 200) begin
            cyc(); #1; n++;
            if (tde2) begin got_d[k] = td2; got_g[k] = gid2; k++; end
        end
        n_tests++;
        if (k != 4) begin n_fail++; $display("FAIL contention_count got %0d want 4", k); end
        for (int i = 0; i < k; i++) begin
            n_tests++;
            if (got_d[i] !== exp_d[i]) begin n_fail++; $display("FAIL contention_data[%0d] got %h want %h", i, got_d[i], exp_d[i]); end
            n_tests++;
            if (got_g[i] !== 1'(i % 2)) begin n_fail++; $display("FAIL contention_grant[%0d] got %0d want %0d", i, got_g[i], i % 2); end
        end
        rv2 = 2'b00;
        n = 0;
        while (st2 != IDLE && n < 100) begin cyc(); #1; n++; end
    endtask

    task automatic test_busy_blocking();
        int  n;
        logic bad;
        cyc(); rv2 = 2'b01; rd2 = 16'h0011; #1;
        cyc(); rv2 = 2'b00;
        n = 0;
        while (st2 != WAIT_DONE && n < 20) begin cyc(); #1; n++; end
        rv2 = 2'b10; rd2 = 16'h2200;
        bad = 1'b0; n = 0;
        #1;
        if (rdy2 !== 2'b00) bad = 1'b1;
        while (dn2 == 2'b00 && n < 200) begin
            cyc(); #1; n++;
            if (rdy2 !== 2'b00) bad = 1'b1;
        end
        n_tests++;
        if (bad !== 1'b0) begin n_fail++; $display("FAIL busy_no_ready got %b want 0", bad); end
        n_tests++;
        if (dn2 !== 2'b01) begin n_fail++; $display("FAIL busy_done0 got %b want 01", dn2); end
        cyc(); #1;
        n_tests++;
        if (!(rdy2 === 2'b10 && st2 === IDLE))
            begin n_fail++; $display("FAIL busy_ready1 got rdy=%b st=%0d want 10 IDLE", rdy2, st2); end
        cyc(); rv2 = 2'b00;
        n = 0;
        while (dn2 == 2'b00 && n < 200) begin cyc(); #1; n++; end
        n_tests++;
        if (dn2 !== 2'b10) begin n_fail++; $display("FAIL busy_done1 got %b want 10", dn2); end
        cyc();
    endtask

    task automatic test_reset_mid();
        int   n;
        logic saw_done;
        cyc(); rv2 = 2'b01; rd2 = 16'h0033; #1;
        cyc(); rv2 = 2'b00;
        n = 0;
        while (dn2 == 2'b00 && n < 200) begin cyc(); #1; n++; end
        cyc(); rv2 = 2'b10; rd2 = 16'h4400; hold2 = 100; #1;
        cyc(); rv2 = 2'b00;
        n = 0;
        while (st2 != WAIT_DONE && n < 20) begin cyc(); #1; n++; end
        cyc();
        rst = 1'b1; #1;
        n_tests++;
        if ({rdy2, dn2, tde2, tse2, ts2, busy2, te2} !== 9'b0) begin
            n_fail++; $display("FAIL midrst_strobes got %b want 0", {rdy2, dn2, tde2, tse2, ts2, busy2, te2});
        end
        n_tests++;
        if (td2 !== 8'h00) begin n_fail++; $display("FAIL midrst_txdata got %h want 00", td2); end
        n_tests++;
        if (st2 !== IDLE) begin n_fail++; $display("FAIL midrst_state got %0d want IDLE", st2); end
        n_tests++;
        if (gid2 !== 1'b0) begin n_fail++; $display("FAIL midrst_grant got %0d want 0", gid2); end
        saw_done = 1'b0;
        hold2 = 3;
        for (int i = 0; i < 3; i++) begin cyc(); if (dn2 !== 2'b00) saw_done = 1'b1; end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin cyc(); #1; if (dn2 !== 2'b00 || st2 !== IDLE) saw_done = 1'b1; end
        n_tests++;
        if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_no_done got %b want 0", saw_done); end
        rv2 = 2'b11; rd2 = 16'h6655; #1;
        n_tests++;
        if (rdy2 !== 2'b01) begin n_fail++; $display("FAIL midrst_rrptr got ready=%b want 01", rdy2); end
        cyc(); rv2 = 2'b00;
        n = 0;
        while (dn2 == 2'b00 && n < 200) begin cyc(); #1; n++; end
        cyc();
    endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        rst = 1'b1; #1; rst = 1'b0;
        stuck2 = 1'b1;
        cyc(); rv2 = 2'b01; rd2 = 16'h0077; #1;
        cyc(); rv2 = 2'b00;
        n = 0;
        while (st2 != WAIT_BUSY && n < 20) begin cyc(); #1; n++; end
        n = 0;
        while (te2 !== 1'b1 && n < 100) begin cyc(); #1; n++; end
        n_tests++;
        if (n != 20) begin n_fail++; $display("FAIL timeout_time got %0d want 20", n); end
        n_tests++;
        if (!(tse2 === 1'b1 && ts2 === 1'b0))
            begin n_fail++; $display("FAIL timeout_clear got en=%b send=%b want 1 0", tse2, ts2); end
        n_tests++;
        if (dn2 !== 2'b00) begin n_fail++; $display("FAIL timeout_done got %b want 00", dn2); end
        cyc(); #1;
        n_tests++;
        if (!(st2 === IDLE && te2 === 1'b0))
            begin n_fail++; $display("FAIL timeout_idle got st=%0d err=%b want IDLE 0", st2, te2); end
        stuck2 = 1'b0;
        rv2 = 2'b11; rd2 = 16'h8877; #1;
        n_tests++;
        if (rdy2 !== 2'b10) begin n_fail++; $display("FAIL timeout_rrptr got %b want 10", rdy2); end
        cyc(); rv2 = 2'b00;
        n = 0;
        while (dn2 == 2'b00 && n < 200) begin cyc(); #1; n++; end
        cyc();
    endtask
`else
    task automatic test_timeout();
        n_tests++;
        if (te_seen2 !== 1'b0) begin n_fail++; $display("FAIL timeout_tied got %b want 0", te_seen2); end
    endtask
`endif

    task automatic test_rr4();
        int n;
        cyc(); rv4 = 4'b0100; rd4 = 32'h00CC_0000; #1;
        n_tests++;
        if (rdy4 !== 4'b0100) begin n_fail++; $display("FAIL rr4_first got %b want 0100", rdy4); end
        cyc(); rv4 = 4'b0000;
        n = 0;
        while (dn4 == 4'b0000 && n < 200) begin cyc(); #1; n++; end
        n_tests++;
        if (dn4 !== 4'b0100) begin n_fail++; $display("FAIL rr4_done2 got %b want 0100", dn4); end
        cyc(); rv4 = 4'b0101; rd4 = 32'h00C2_00C0; #1;
        n_tests++;
        if (rdy4 !== 4'b0001) begin n_fail++; $display("FAIL rr4_wrap got %b want 0001", rdy4); end
        cyc(); rv4 = 4'b0000; #1;
        n_tests++;
        if (!(gid4 === 2'd0 && tde4 === 1'b1 && td4 === 8'hC0))
            begin n_fail++; $display("FAIL rr4_load got gid=%0d en=%b data=%h want 0 1 C0", gid4, tde4, td4); end
        n = 0;
        while (dn4 == 4'b0000 && n < 200) begin cyc(); #1; n++; end
        cyc(); rv4 = 4'b1101; #1;
        n_tests++;
        if (rdy4 !== 4'b0100) begin n_fail++; $display("FAIL rr4_skip got %b want 0100", rdy4); end
        cyc(); rv4 = 4'b0000;
        n = 0;
        while (dn4 == 4'b0000 && n < 200) begin cyc(); #1; n++; end
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_busy_blocking();
        test_reset_mid();
        test_timeout();
        test_rr4();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
